serial_frame_tx: RTL and testbench

Parallel-in, serial-out framed transmitter. It is the transmit end of the team's single-wire serial link and drives the line that the flip-flop-based receiver samples. It accepts one DATA_W-bit word per valid/ready handshake and shifts it out as a frame: start bit, data LSB-first, optional even parity bit, stop bit. Each bit is held for CLKS_PER_BIT clock cycles.

---
 rtl/serial_frame_tx.sv | 181 ++++++++++++++++++
 tb/tb_serial_frame_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// -----------------------------------------------------------------------------
// serial_frame_tx
//
// Parallel-in, serial-out framed transmitter for the single-wire serial link.
// One word is taken per valid/ready handshake and shifted out as
//   start(0), data LSB-first, optional even-parity bit, stop(1)
// with every bit held for CLKS_PER_BIT clock cycles. The line idles high.
//
// Handshake: a word transfers at a rising edge where load_valid and
// load_ready are both 1. load_ready is high only in IDLE. The producer may
// hold load_valid as long as it likes. A word offered while busy is not
// queued; it is taken only once load_ready returns high.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   data_in     in   [DATA_W-1:0] word to send, sampled at the accepting edge
//   load_valid  in   producer has a word on data_in
//   load_ready  out  transmitter can accept a word (registered)
//   tx_out      out  serial line, idles high (registered)
//   busy        out  frame in progress (registered)
//   done        out  one-cycle pulse in the cycle after the stop bit ends
//   state_dbg   out  [2:0] current FSM state encoding, for observation
// -----------------------------------------------------------------------------
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              load_valid,
    output logic              load_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              done,
    output logic [2:0]        state_dbg
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state, state_n;
    logic [CW-1:0]     cyc_cnt, cyc_n;
    logic [BW-1:0]     bit_cnt, bit_n;
    logic [DATA_W-1:0] shift, shift_n;
    logic              parity, parity_n;
    logic              tx_n, ready_n, busy_n, done_n;
    logic              bit_end;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity     <= 1'b0;
            tx_out     <= 1'b1;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            cyc_cnt    <= cyc_n;
            bit_cnt    <= bit_n;
            shift      <= shift_n;
            parity     <= parity_n;
            tx_out     <= tx_n;
            load_ready <= ready_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        cyc_n    = cyc_cnt;
        bit_n    = bit_cnt;
        shift_n  = shift;
        parity_n = parity;
        tx_n     = tx_out;
        ready_n  = load_ready;
        busy_n   = busy;
        done_n   = 1'b0;
        bit_end  = (cyc_cnt == CYC_LAST);

        case (state)
            IDLE: begin
                tx_n = 1'b1;
                if (load_valid && load_ready) begin
                    shift_n  = data_in;
                    parity_n = ^data_in;
                    state_n  = START;
                    tx_n     = 1'b0;
                    ready_n  = 1'b0;
                    busy_n   = 1'b1;
                    cyc_n    = '0;
                    bit_n    = '0;
                end
            end

            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    tx_n    = shift[0];
                    cyc_n   = '0;
                end else begin
                    cyc_n = cyc_cnt + 1'b1;
                end
            end

            DATA: begin
                if (bit_end) begin
                    cyc_n   = '0;
                    shift_n = shift >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        // Bit counter parks at its terminal value until the next accept.
                        if (PARITY_EN != 0) begin
                            state_n = PARITY;
                            tx_n    = parity;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                        // Next data bit is the LSB of the already-shifted word.
                        tx_n  = shift_n[0];
                    end
                end else begin
                    cyc_n = cyc_cnt + 1'b1;
                end
            end

            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                    cyc_n   = '0;
                end else begin
                    cyc_n = cyc_cnt + 1'b1;
                end
            end

            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    tx_n    = 1'b1;
                    cyc_n   = '0;
                    done_n  = 1'b1;
                    ready_n = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    cyc_n = cyc_cnt + 1'b1;
                end
            end

            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                ready_n = 1'b1;
                busy_n  = 1'b0;
                cyc_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_tx
//
// Three instances of serial_frame_tx:
//   u0: DATA_W=8, CLKS_PER_BIT=4, PARITY_EN=0
//   u1: DATA_W=8, CLKS_PER_BIT=4, PARITY_EN=1
//   u2: DATA_W=4, CLKS_PER_BIT=1, PARITY_EN=0
// Expected frames are written as packed vectors in transmit order
// (bit 0 is sent first): {stop, [parity], data, start}.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_serial_frame_tx;

    logic        clk;
    logic        rst_n;
    logic [15:0] din;
    logic [2:0]  lv;
    logic [2:0]  rd;
    logic [2:0]  tx;
    logic [2:0]  bz;
    logic [2:0]  dn;
    logic [2:0]  st0, st1, st2;

    int checks;
    int errors;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0)) u0 (
        .clk(clk), .reset_n(rst_n), .data_in(din[7:0]), .load_valid(lv[0]),
        .load_ready(rd[0]), .tx_out(tx[0]), .busy(bz[0]), .done(dn[0]),
        .state_dbg(st0)
    );

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) u1 (
        .clk(clk), .reset_n(rst_n), .data_in(din[7:0]), .load_valid(lv[1]),
        .load_ready(rd[1]), .tx_out(tx[1]), .busy(bz[1]), .done(dn[1]),
        .state_dbg(st1)
    );

    serial_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1), .PARITY_EN(0)) u2 (
        .clk(clk), .reset_n(rst_n), .data_in(din[3:0]), .load_valid(lv[2]),
        .load_ready(rd[2]), .tx_out(tx[2]), .busy(bz[2]), .done(dn[2]),
        .state_dbg(st2)
    );

    // ---------------- driver tasks ----------------
    // Present a word at the falling edge; it is taken at the next rising edge.
    task automatic offer(input int idx, input logic [15:0] word, input bit keep_valid);
        @(negedge clk);
        din     = word;
        lv[idx] = 1'b1;
        @(posedge clk);
        #1;
        if (!keep_valid) lv[idx] = 1'b0;
    endtask

    // Walk a frame after its accepting edge, checking every cycle, and finish
    // at the falling edge of the done cycle.
    task automatic run_frame(input int idx, input logic [18:0] frame, input int nbits,
                             input int cpb, input string name);
        for (int k = 0; k < nbits; k++) begin
            for (int c = 0; c < cpb; c++) begin
                @(negedge clk);
                checks++;
                if (tx[idx] !== frame[k]) begin
                    errors++;
                    $display("FAIL %s tx bit=%0d cyc=%0d got %b exp %b", name, k, c, tx[idx], frame[k]);
                end
                checks++;
                if ({bz[idx], rd[idx], dn[idx]} !== 3'b100) begin
                    errors++;
                    $display("FAIL %s flags bit=%0d cyc=%0d got busy/ready/done=%b exp 100",
                             name, k, c, {bz[idx], rd[idx], dn[idx]});
                end
            end
        end
        @(negedge clk);
        checks++;
        if ({tx[idx], bz[idx], rd[idx], dn[idx]} !== 4'b1011) begin
            errors++;
            $display("FAIL %s done_cycle got tx/busy/ready/done=%b exp 1011",
                     name, {tx[idx], bz[idx], rd[idx], dn[idx]});
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        din   = '0;
        lv    = '0;
        #12;
        checks++;
        if ({tx, rd, bz, dn} !== {3'b111, 3'b111, 3'b000, 3'b000}) begin
            errors++;
            $display("FAIL reset_outputs got tx=%b rdy=%b busy=%b done=%b exp 111 111 000 000",
                     tx, rd, bz, dn);
        end
        checks++;
        if ({st0, st1, st2} !== 9'd0) begin
            errors++;
            $display("FAIL reset_state got %0d %0d %0d exp 0 0 0", st0, st1, st2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx[0], rd[0], bz[0], dn[0]} !== 4'b1100) begin
            errors++;
            $display("FAIL idle_after_reset got %b exp 1100", {tx[0], rd[0], bz[0], dn[0]});
        end
    endtask

    task automatic test_basic;
        offer(0, 16'h00A5, 1'b0);
        run_frame(0, 19'h0034A, 10, 4, "basic_a5");
        @(negedge clk);
        checks++;
        if (dn[0] !== 1'b0) begin
            errors++;
            $display("FAIL done_single_pulse got %b exp 0", dn[0]);
        end
    endtask

    task automatic test_parity;
        offer(1, 16'h0007, 1'b0);
        run_frame(1, 19'h0060E, 11, 4, "parity_07");
        offer(1, 16'h0003, 1'b0);
        run_frame(1, 19'h00406, 11, 4, "parity_03");
    endtask

    task automatic test_busy_ignore;
        offer(0, 16'h003C, 1'b1);
        din = 16'h00FF;
        run_frame(0, 19'h00278, 10, 4, "busy_3c");
        run_frame(0, 19'h003FE, 10, 4, "busy_ff");
        lv[0] = 1'b0;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        offer(0, 16'h0001, 1'b1);
        din = 16'h0080;
        run_frame(0, 19'h00202, 10, 4, "b2b_01");
        run_frame(0, 19'h00300, 10, 4, "b2b_80");
        lv[0] = 1'b0;
        @(negedge clk);
        checks++;
        if ({bz[0], dn[0]} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_no_third got busy/done=%b exp 00", {bz[0], dn[0]});
        end
    endtask

    task automatic test_reset_mid_frame;
        @(negedge clk);
        offer(0, 16'h0055, 1'b0);
        // Start bit plus data bits 0..2, then into data bit 3.
        repeat (17) @(negedge clk);
        checks++;
        if ({tx[0], bz[0]} !== 2'b01) begin
            errors++;
            $display("FAIL mid_frame_bit3 got tx/busy=%b exp 01", {tx[0], bz[0]});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({tx[0], bz[0], rd[0], dn[0]} !== 4'b1010) begin
            errors++;
            $display("FAIL async_abort got tx/busy/ready/done=%b exp 1010",
                     {tx[0], bz[0], rd[0], dn[0]});
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({tx[0], bz[0], rd[0], dn[0]} !== 4'b1010) begin
                errors++;
                $display("FAIL post_abort_idle cyc=%0d got %b exp 1010", i,
                         {tx[0], bz[0], rd[0], dn[0]});
            end
        end
        offer(0, 16'h0055, 1'b0);
        run_frame(0, 19'h002AA, 10, 4, "resend_55");
    endtask

    task automatic test_one_clk_per_bit;
        @(negedge clk);
        offer(2, 16'h0009, 1'b0);
        run_frame(2, 19'h00032, 6, 1, "cpb1_9");
        @(negedge clk);
        checks++;
        if ({tx[2], rd[2], dn[2]} !== 3'b110) begin
            errors++;
            $display("FAIL cpb1_after got tx/ready/done=%b exp 110", {tx[2], rd[2], dn[2]});
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_basic;
        test_parity;
        test_busy_ignore;
        test_back_to_back;
        test_reset_mid_frame;
        test_one_clk_per_bit;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
